// File: rtl/alct_arb_pkg.sv
// Shared types and helpers for the pattern track arbiter: candidate format,
// counter widths and the winner-ranking rule.
package alct_arb_pkg;

    localparam int unsigned QW    = 2;
    localparam int unsigned DTW   = 3;
    localparam int unsigned NTRKW = 16;
    localparam logic [NTRKW-1:0] NTRK_MAX = '1;

    typedef struct packed {
        logic          valid;
        logic [QW-1:0] q;
        logic          accel;
    } cand_t;

    // Keys are scanned from index 0 upward, so a strict compare keeps the lowest index on a tie.
    function automatic logic beats(input logic [QW-1:0] q_new,
                                   input logic [QW-1:0] q_best,
                                   input logic          best_found);
        return !best_found || (q_new > q_best);
    endfunction

endpackage

// File: rtl/arb_deadtime_cell.sv
// Per-key dead-time counter: load on a win, count down to zero, key masked while nonzero.
module arb_deadtime_cell
    import alct_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           load,
    input  logic [DTW-1:0] dead_time,
    output logic           masked
);

    logic [DTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = dead_time;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign masked = (cnt_q != '0);

endmodule

// File: rtl/pattern_track_arbiter.sv
// Selects one best collision/accelerator track per bunch crossing across NKEY key groups,
// with per-key dead-time ghost suppression and a saturating track counter.
module pattern_track_arbiter
    import alct_arb_pkg::*;
#(
    parameter int unsigned NKEY = 16,
    parameter int unsigned KEYW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [NKEY-1:0]   vacp,
    input  logic [2*NKEY-1:0] sacp,
    input  logic [NKEY-1:0]   va,
    input  logic [2*NKEY-1:0] sa,
    input  logic              acc_first,
    input  logic [DTW-1:0]    dead_time,
    input  logic              cnt_clr,
    output logic              best_valid,
    output logic [KEYW-1:0]   best_key,
    output logic [QW-1:0]     best_quality,
    output logic              best_accel,
    output logic [NTRKW-1:0]  ntrk
);

    cand_t [NKEY-1:0] cand_q, cand_d;
    logic  [NKEY-1:0] masked, load;

    logic            win_found;
    logic [KEYW-1:0] win_idx;
    logic [QW-1:0]   win_q;
    logic            win_acc;

    always_comb begin
        for (int k = 0; k < NKEY; k++) begin
            cand_d[k] = '0;
            if (va[k] && (!vacp[k] || acc_first)) begin
                cand_d[k].valid = 1'b1;
                cand_d[k].q     = sa[2*k +: 2];
                cand_d[k].accel = 1'b1;
            end else if (vacp[k]) begin
                cand_d[k].valid = 1'b1;
                cand_d[k].q     = sacp[2*k +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
        end else if (!run) begin
            cand_q <= '0;
        end else begin
            cand_q <= cand_d;
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_q     = '0;
        win_acc   = 1'b0;
        for (int k = 0; k < NKEY; k++) begin
            if (cand_q[k].valid && !masked[k] && beats(cand_q[k].q, win_q, win_found)) begin
                win_found = 1'b1;
                win_idx   = KEYW'(k);
                win_q     = cand_q[k].q;
                win_acc   = cand_q[k].accel;
            end
        end
    end

    // Winner and its immediate neighbours; the edges of the key range do not wrap.
    always_comb begin
        for (int k = 0; k < NKEY; k++) begin
            load[k] = win_found &&
                      ((KEYW'(k) == win_idx) ||
                       ((k > 0) && (KEYW'(k - 1) == win_idx)) ||
                       ((k < NKEY - 1) && (KEYW'(k + 1) == win_idx)));
        end
    end

    for (genvar g = 0; g < NKEY; g++) begin : g_dt
        arb_deadtime_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (!run),
            .load      (load[g]),
            .dead_time (dead_time),
            .masked    (masked[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid   <= 1'b0;
            best_key     <= '0;
            best_quality <= '0;
            best_accel   <= 1'b0;
        end else if (!run) begin
            best_valid <= 1'b0;
        end else begin
            best_valid <= win_found;
            if (win_found) begin
                best_key     <= win_idx;
                best_quality <= win_q;
                best_accel   <= win_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ntrk <= '0;
        end else if (cnt_clr) begin
            ntrk <= '0;
        end else if (run && win_found && (ntrk != NTRK_MAX)) begin
            ntrk <= ntrk + 1'b1;
        end
    end

endmodule

// File: tb/tb_pattern_track_arbiter.sv
// Directed self-checking bench for pattern_track_arbiter.
module tb_pattern_track_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] vacp;
    logic [31:0] sacp;
    logic [15:0] va;
    logic [31:0] sa;
    logic        acc_first;
    logic [2:0]  dead_time;
    logic        cnt_clr;
    logic        best_valid;
    logic [3:0]  best_key;
    logic [1:0]  best_quality;
    logic        best_accel;
    logic [15:0] ntrk;

    int checks   = 0;
    int failures = 0;

    pattern_track_arbiter #(
        .NKEY (16),
        .KEYW (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .vacp         (vacp),
        .sacp         (sacp),
        .va           (va),
        .sa           (sa),
        .acc_first    (acc_first),
        .dead_time    (dead_time),
        .cnt_clr      (cnt_clr),
        .best_valid   (best_valid),
        .best_key     (best_key),
        .best_quality (best_quality),
        .best_accel   (best_accel),
        .ntrk         (ntrk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vacp = '0;
        sacp = '0;
        va   = '0;
        sa   = '0;
    endtask

    task automatic set_col(input int k, input logic [1:0] q);
        vacp[k]       = 1'b1;
        sacp[2*k +: 2] = q;
    endtask

    task automatic set_acc(input int k, input logic [1:0] q);
        va[k]       = 1'b1;
        sa[2*k +: 2] = q;
    endtask

    task automatic flush();
        clear_inputs();
        run = 1'b0;
        tick();
        run = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (best_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", best_valid);
        end
        checks++;
        if (best_key !== 4'd0) begin
            failures++; $display("FAIL reset_key got=%0d exp=0", best_key);
        end
        checks++;
        if (best_quality !== 2'd0) begin
            failures++; $display("FAIL reset_quality got=%0d exp=0", best_quality);
        end
        checks++;
        if (best_accel !== 1'b0) begin
            failures++; $display("FAIL reset_accel got=%0b exp=0", best_accel);
        end
        checks++;
        if (ntrk !== 16'd0) begin
            failures++; $display("FAIL reset_ntrk got=%0d exp=0", ntrk);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_col(5, 2'd2);
        tick();
        clear_inputs();
        tick();
        checks++;
        if ({best_valid, best_key, best_quality, best_accel} !== {1'b1, 4'd5, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL single_track got=v%0b k%0d q%0d a%0b exp=v1 k5 q2 a0",
                     best_valid, best_key, best_quality, best_accel);
        end
        checks++;
        if (ntrk !== 16'd1) begin
            failures++; $display("FAIL single_ntrk got=%0d exp=1", ntrk);
        end
        tick();
        checks++;
        if (best_valid !== 1'b0 || best_key !== 4'd5) begin
            failures++;
            $display("FAIL single_hold got=v%0b k%0d exp=v0 k5", best_valid, best_key);
        end
    endtask

    task automatic test_quality();
        set_col(3, 2'd1);
        set_col(10, 2'd3);
        tick();
        clear_inputs();
        set_col(4, 2'd2);
        set_col(9, 2'd2);
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd10 || best_quality !== 2'd3) begin
            failures++;
            $display("FAIL quality_pick got=v%0b k%0d q%0d exp=v1 k10 q3",
                     best_valid, best_key, best_quality);
        end
        clear_inputs();
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd4 || best_quality !== 2'd2) begin
            failures++;
            $display("FAIL tie_lowest got=v%0b k%0d q%0d exp=v1 k4 q2",
                     best_valid, best_key, best_quality);
        end
    endtask

    task automatic test_dead_time();
        dead_time = 3'd3;
        set_col(7, 2'd3);
        set_col(8, 2'd1);
        tick();
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd7) begin
            failures++; $display("FAIL dt_first got=v%0b k%0d exp=v1 k7", best_valid, best_key);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (best_valid !== 1'b0) begin
                failures++;
                $display("FAIL dt_masked t+%0d got=v%0b k%0d exp=v0", i, best_valid, best_key);
            end
        end
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd7) begin
            failures++; $display("FAIL dt_again got=v%0b k%0d exp=v1 k7", best_valid, best_key);
        end
        clear_inputs();
        tick();
        flush();
        dead_time = 3'd0;
        checks++;
        if (ntrk !== 16'd5) begin
            failures++; $display("FAIL dt_ntrk got=%0d exp=5", ntrk);
        end
    endtask

    task automatic test_conflict();
        set_acc(0, 2'd1);
        set_col(0, 2'd3);
        acc_first = 1'b1;
        tick();
        acc_first = 1'b0;
        tick();
        checks++;
        if ({best_valid, best_key, best_quality, best_accel} !== {1'b1, 4'd0, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL conflict_acc got=v%0b k%0d q%0d a%0b exp=v1 k0 q1 a1",
                     best_valid, best_key, best_quality, best_accel);
        end
        clear_inputs();
        tick();
        checks++;
        if ({best_valid, best_key, best_quality, best_accel} !== {1'b1, 4'd0, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL conflict_col got=v%0b k%0d q%0d a%0b exp=v1 k0 q3 a0",
                     best_valid, best_key, best_quality, best_accel);
        end
        tick();
    endtask

    task automatic test_boundary();
        dead_time = 3'd2;
        set_col(15, 2'd3);
        set_col(14, 2'd2);
        set_col(0, 2'd1);
        tick();
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd15) begin
            failures++; $display("FAIL edge_k15 got=v%0b k%0d exp=v1 k15", best_valid, best_key);
        end
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd0 || best_quality !== 2'd1) begin
            failures++;
            $display("FAIL edge_nowrap got=v%0b k%0d q%0d exp=v1 k0 q1",
                     best_valid, best_key, best_quality);
        end
        tick();
        checks++;
        if (best_valid !== 1'b0) begin
            failures++; $display("FAIL edge_masked got=v%0b k%0d exp=v0", best_valid, best_key);
        end
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd15) begin
            failures++; $display("FAIL edge_rewin got=v%0b k%0d exp=v1 k15", best_valid, best_key);
        end
        flush();
        dead_time = 3'd0;
        checks++;
        if (ntrk !== 16'd10) begin
            failures++; $display("FAIL edge_ntrk got=%0d exp=10", ntrk);
        end
    endtask

    task automatic test_run_flush();
        set_col(2, 2'd1);
        tick();
        tick();
        checks++;
        if (best_valid !== 1'b1 || best_key !== 4'd2) begin
            failures++; $display("FAIL run_pre got=v%0b k%0d exp=v1 k2", best_valid, best_key);
        end
        run = 1'b0;
        tick();
        checks++;
        if (best_valid !== 1'b0 || best_key !== 4'd2 || ntrk !== 16'd11) begin
            failures++;
            $display("FAIL run_low got=v%0b k%0d n%0d exp=v0 k2 n11", best_valid, best_key, ntrk);
        end
        run = 1'b1;
        tick();
        checks++;
        if (best_valid !== 1'b0) begin
            failures++; $display("FAIL run_resume0 got=v%0b exp=v0", best_valid);
        end
        clear_inputs();
        tick();
        checks++;
        if (best_valid !== 1'b1 || ntrk !== 16'd12) begin
            failures++; $display("FAIL run_resume1 got=v%0b n%0d exp=v1 n12", best_valid, ntrk);
        end
        tick();
    endtask

    task automatic test_cnt_clr();
        set_col(6, 2'd2);
        tick();
        clear_inputs();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (best_valid !== 1'b1 || ntrk !== 16'd0) begin
            failures++; $display("FAIL cnt_clr got=v%0b n%0d exp=v1 n0", best_valid, ntrk);
        end
        tick();
    endtask

    task automatic test_saturation();
        set_col(1, 2'd1);
        repeat (65540) tick();
        checks++;
        if (best_valid !== 1'b1 || ntrk !== 16'hFFFF) begin
            failures++; $display("FAIL saturate got=v%0b n%h exp=v1 nffff", best_valid, ntrk);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({best_valid, best_key, best_quality, best_accel, ntrk} !== '0) begin
            failures++;
            $display("FAIL async_reset got=v%0b k%0d q%0d a%0b n%0d exp=all0",
                     best_valid, best_key, best_quality, best_accel, ntrk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b1;
        acc_first = 1'b0;
        dead_time = 3'd0;
        cnt_clr   = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_quality();
        test_dead_time();
        test_conflict();
        test_boundary();
        test_run_flush();
        test_cnt_clr();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
